// File: rtl/box_animator.sv
// Draws a solid box, waits for a pacing tick, erases it, moves it one step and redraws it.
// Pixels are emitted one per accepted write so a slow VGA writer can stall the sweep.
module box_animator #(
  parameter int         XSCREEN = 160,
  parameter int         YSCREEN = 120,
  parameter int         XDIM    = 10,
  parameter int         YDIM    = 10,
  parameter int         STEP    = 1,
  parameter int         WRAP    = 1,
  parameter int         X0      = 39,
  parameter int         Y0      = 59,
  parameter logic [2:0] BG      = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       go,
  input  logic [3:0] dir_req,
  input  logic [2:0] colour,
  input  logic       plot_ready,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic [1:0] dir,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAW  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_MOVE  = 3'd4;

  localparam logic [8:0] X_LIM  = 9'(XSCREEN - XDIM);
  localparam logic [7:0] Y_LIM  = 8'(YSCREEN - YDIM);
  localparam logic [8:0] X_STEP = 9'(STEP);
  localparam logic [7:0] Y_STEP = 8'(STEP);
  localparam logic [7:0] X_LAST = 8'(XDIM - 1);
  localparam logic [6:0] Y_LAST = 7'(YDIM - 1);

  logic [2:0] state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] draw_col;
  logic [1:0] next_dir;
  logic [1:0] req_dir;
  logic       req_valid;
  logic [8:0] x_wide;
  logic [7:0] y_wide;
  logic [7:0] new_x;
  logic [6:0] new_y;

  always_comb begin
    req_valid = |dir_req;
    req_dir   = 2'd0;
    if (dir_req[0])      req_dir = 2'd0;
    else if (dir_req[1]) req_dir = 2'd1;
    else if (dir_req[2]) req_dir = 2'd2;
    else if (dir_req[3]) req_dir = 2'd3;
  end

  // Position update is evaluated one bit wider than the registers so edge tests never truncate.
  always_comb begin
    x_wide = {1'b0, pos_x};
    y_wide = {1'b0, pos_y};
    new_x  = pos_x;
    new_y  = pos_y;
    case (next_dir)
      2'd0: begin
        if ((x_wide + X_STEP) > X_LIM) new_x = (WRAP != 0) ? 8'd0 : X_LIM[7:0];
        else                           new_x = 8'(x_wide + X_STEP);
      end
      2'd1: begin
        if ((y_wide + Y_STEP) > Y_LIM) new_y = (WRAP != 0) ? 7'd0 : Y_LIM[6:0];
        else                           new_y = 7'(y_wide + Y_STEP);
      end
      2'd2: begin
        if (y_wide < Y_STEP) new_y = (WRAP != 0) ? Y_LIM[6:0] : 7'd0;
        else                 new_y = 7'(y_wide - Y_STEP);
      end
      default: begin
        if (x_wide < X_STEP) new_x = (WRAP != 0) ? X_LIM[7:0] : 8'd0;
        else                 new_x = 8'(x_wide - X_STEP);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pos_x    <= 8'(X0);
      pos_y    <= 7'(Y0);
      dir      <= 2'd0;
      next_dir <= 2'd0;
      cx       <= 8'd0;
      cy       <= 7'd0;
      draw_col <= 3'd0;
    end else begin
      // A request that would reverse the box onto itself is dropped.
      if (req_valid && (req_dir != ~dir)) next_dir <= req_dir;
      case (state)
        S_IDLE: begin
          if (go && tick) begin
            state    <= S_DRAW;
            draw_col <= colour;
            cx       <= 8'd0;
            cy       <= 7'd0;
          end
        end
        S_DRAW, S_ERASE: begin
          if (plot_ready) begin
            if (cx == X_LAST) begin
              cx <= 8'd0;
              if (cy == Y_LAST) begin
                cy    <= 7'd0;
                state <= (state == S_DRAW) ? S_WAIT : S_MOVE;
              end else begin
                cy <= cy + 7'd1;
              end
            end else begin
              cx <= cx + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (go && tick) begin
            state <= S_ERASE;
            cx    <= 8'd0;
            cy    <= 7'd0;
          end
        end
        S_MOVE: begin
          dir      <= next_dir;
          pos_x    <= new_x;
          pos_y    <= new_y;
          state    <= S_DRAW;
          draw_col <= colour;
          cx       <= 8'd0;
          cy       <= 7'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    plot       = (state == S_DRAW) || (state == S_ERASE);
    busy       = plot || (state == S_MOVE);
    x_out      = pos_x + cx;
    y_out      = pos_y + cy;
    colour_out = (state == S_ERASE) ? BG : draw_col;
  end

endmodule

// File: doc/box_animator.md
BOX_ANIMATOR -- requirements
Module: box_animator

Interface
REQ-001 Parameter XSCREEN, default 160: screen width, pixels.
REQ-002 Parameter YSCREEN, default 120: screen height, pixels.
REQ-003 Parameter XDIM, default 10: box width, range 1..XSCREEN.
REQ-004 Parameter YDIM, default 10: box height, range 1..YSCREEN.
REQ-005 Parameter STEP, default 1: pixels moved per MOVE, range 1..min(XSCREEN-XDIM, YSCREEN-YDIM).
REQ-006 Parameter WRAP, default 1: 1 = wrap at edges, 0 = clamp at edges.
REQ-007 Parameter X0, default 39; Y0, default 59: reset position of the box's top-left corner.
REQ-008 Parameter BG, default 3'b000: erase colour.
REQ-009 Clock  in  1  single clock; all state changes on its rising edge.
REQ-010 Reset  in  1  synchronous, active-high reset.
REQ-011 tick  in  1  one-cycle frame/pacing pulse.
REQ-012 go  in  1  start/run enable.
REQ-013 dir_req  in  4  direction requests, active-high: bit0 right, bit1 down, bit2 up, bit3 left.
REQ-014 colour  in  3  box colour.
REQ-015 plot_ready  in  1  VGA writer accepts the current pixel.
REQ-016 x_out  out  8  pixel x; y_out  out  7  pixel y.
REQ-017 colour_out  out  3  pixel colour; plot  out  1  pixel write strobe.
REQ-018 pos_x  out  8; pos_y  out  7: current box top-left corner.
REQ-019 dir  out  2  latched direction: 0 right, 1 down, 2 up, 3 left.
REQ-020 busy  out  1  high in DRAW, ERASE, MOVE.

Function
REQ-021 FSM states: IDLE, DRAW, WAIT, ERASE, MOVE.
REQ-022 IDLE: go=1 and tick=1 in the same cycle -> DRAW next cycle; otherwise stay in IDLE.
REQ-023 Entering DRAW: the FSM latches colour into draw_col and clears the pixel counters cx, cy.
REQ-024 DRAW/ERASE: plot=1; x_out=pos_x+cx; y_out=pos_y+cy; colour_out=draw_col in DRAW, BG in ERASE.
REQ-025 Counters advance only on plot&plot_ready, row-major: cx increments; at cx=XDIM-1, cx->0 and cy increments.
REQ-026 plot_ready=0: hold x_out, y_out and the counters unchanged (stall).
REQ-027 Last pixel (cx=XDIM-1, cy=YDIM-1) accepted in DRAW -> WAIT; in ERASE -> MOVE. Each pass writes exactly XDIM*YDIM pixels.
REQ-028 WAIT: plot=0; tick=1 and go=1 -> ERASE with counters cleared; go=0 -> stay in WAIT (pause, box remains drawn).
REQ-029 MOVE: one cycle; pos and dir update per REQ-031..033; next state DRAW.
REQ-030 Direction capture, every cycle: the highest-priority set dir_req bit (bit0 > bit1 > bit2 > bit3) loads next_dir, unless it is the opposite of dir (right/left, up/down), in which case it is ignored; dir_req=0 leaves next_dir unchanged.
REQ-031 In MOVE, dir <= next_dir, then the position moves by STEP in the new dir.
REQ-032 Right/down overflow (pos+STEP > SCREEN-DIM): WRAP=1 -> 0; WRAP=0 -> SCREEN-DIM.
REQ-033 Left/up underflow (pos < STEP): WRAP=1 -> SCREEN-DIM; WRAP=0 -> 0. Arithmetic is one bit wider than pos so that no intermediate truncation occurs.
REQ-034 Changes to colour during DRAW do not affect the current pass.

Reset
REQ-035 Reset=1 at any cycle, including mid-DRAW or mid-ERASE: next cycle state=IDLE, pos_x=X0, pos_y=Y0, dir=0, next_dir=0, cx=cy=0, draw_col=0, plot=0, busy=0; no erase of partially drawn pixels.
REQ-036 Reset overrides tick, go, dir_req and plot_ready.

Verification
REQ-037 Defaults, plot_ready=1, go=1, tick pulse in IDLE, colour=3'b100 -> 100 plot cycles, first pixel (39,59), last (48,68), all colour 4, then WAIT.
REQ-038 plot_ready toggled 1/0 each cycle during DRAW -> 100 plots accepted in 200 cycles; no pixel repeated or skipped.
REQ-039 dir=right, dir_req=4'b1000 (left) -> ignored; dir_req=4'b0110 -> next_dir=down (bit1 wins); after MOVE pos=(39,60).
REQ-040 WRAP=1, pos_x=150, right, STEP=1 -> pos_x=0 after MOVE; WRAP=0 -> stays 150.
REQ-041 WRAP=1, pos_y=0, up -> pos_y=110 after MOVE; dir=up.
REQ-042 Reset asserted at pixel 37 of ERASE -> IDLE, pos=(39,59), plot=0 on the following cycle.
